// File: rtl/rb_access_arbiter.sv
// rb_access_arbiter: arbitrates I2C and UART requesters onto a single register-bank port
module rb_access_arbiter #(
    parameter int RD_LATENCY   = 1,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       i2c_req,
    input  logic       i2c_we,
    input  logic [7:0] i2c_addr,
    input  logic [7:0] i2c_wdata,
    input  logic       i2c_lock,
    output logic       i2c_ack,
    output logic [7:0] i2c_rdata,
    input  logic       uart_req,
    input  logic       uart_we,
    input  logic [7:0] uart_addr,
    input  logic [7:0] uart_wdata,
    input  logic       uart_lock,
    output logic       uart_ack,
    output logic [7:0] uart_rdata,
    output logic [7:0] rb_address,
    output logic [7:0] rb_data_write,
    output logic       rb_reg_en,
    output logic       rb_write_en,
    input  logic [7:0] rb_data_read,
    output logic [1:0] grant_mon,
    output logic       lock_err
);
    typedef enum logic [2:0] {IDLE, ACCESS, WAIT_RD, ACK, LOCKED} state_t;

    state_t      state, state_nx;
    logic [1:0]  rst_sync;
    logic        owner, last_served, last_served_nx;
    logic        take, take_uart, lock_err_nx;
    logic        owner_req, owner_lock, rd_done, timeout;
    logic        lat_we;
    logic [7:0]  lat_addr, lat_wdata;
    logic [2:0]  rd_cnt;
    logic [15:0] lock_cnt;

    assign owner_req  = owner ? uart_req : i2c_req;
    assign owner_lock = owner ? uart_lock : i2c_lock;
    assign rd_done    = (state == WAIT_RD) && (rd_cnt == 3'(RD_LATENCY - 1));
    assign timeout    = (state == LOCKED) && (lock_cnt == 16'(LOCK_TIMEOUT - 1));

    // Reset release synchroniser: arbitration is held off until two edges after release
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    // Next-state, grant decision and last_served update
    always_comb begin
        state_nx       = state;
        take           = 1'b0;
        take_uart      = owner;
        last_served_nx = last_served;
        lock_err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_sync[1] && (i2c_req || uart_req)) begin
                    take      = 1'b1;
                    take_uart = (i2c_req && uart_req) ? ~last_served : uart_req;
                    state_nx  = ACCESS;
                end
            end
            ACCESS:  state_nx = lat_we ? ACK : WAIT_RD;
            WAIT_RD: state_nx = rd_done ? ACK : WAIT_RD;
            ACK: begin
                state_nx       = owner_lock ? LOCKED : IDLE;
                last_served_nx = owner_lock ? last_served : owner;
            end
            LOCKED: begin
                if (timeout) begin
                    state_nx       = IDLE;
                    last_served_nx = owner;
                    lock_err_nx    = 1'b1;
                end else if (owner_req) begin
                    take     = 1'b1;
                    state_nx = ACCESS;
                end else if (!owner_lock) begin
                    state_nx       = IDLE;
                    last_served_nx = owner;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, fairness pointer and timeout pulse registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= IDLE;
            last_served <= 1'b1;
            lock_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            last_served <= last_served_nx;
            lock_err    <= lock_err_nx;
        end
    end

    // Capture owner and request fields at grant so later requester changes cannot disturb the access
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 8'h00;
        end else if (take) begin
            owner     <= take_uart;
            lat_we    <= take_uart ? uart_we : i2c_we;
            lat_addr  <= take_uart ? uart_addr : i2c_addr;
            lat_wdata <= take_uart ? uart_wdata : i2c_wdata;
        end
    end

    // Read-latency and lock-hold counters; both restart from zero on entry to their state
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_cnt   <= 3'd0;
            lock_cnt <= 16'd0;
        end else begin
            rd_cnt   <= (state == WAIT_RD && !rd_done) ? rd_cnt + 3'd1 : 3'd0;
            lock_cnt <= (state == LOCKED) ? lock_cnt + 16'd1 : 16'd0;
        end
    end

    // Per-port read data, loaded on the final read-latency edge and held until that port's next read
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            i2c_rdata  <= 8'h00;
            uart_rdata <= 8'h00;
        end else if (rd_done) begin
            if (owner) uart_rdata <= rb_data_read;
            else       i2c_rdata  <= rb_data_read;
        end
    end

    assign i2c_ack       = (state == ACK) && !owner;
    assign uart_ack      = (state == ACK) && owner;
    assign grant_mon     = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign rb_reg_en     = (state == ACCESS);
    assign rb_write_en   = (state == ACCESS) && lat_we;
    assign rb_address    = (state == ACCESS || state == WAIT_RD) ? lat_addr : 8'h00;
    assign rb_data_write = (state == ACCESS) ? lat_wdata : 8'h00;
endmodule

// File: tb/tb_rb_access_arbiter.sv
// tb_rb_access_arbiter: vector table plus corner-case sequences, checked through an ordered scoreboard
module tb_rb_access_arbiter;
    localparam int RD_LAT  = 1;
    localparam int LOCK_TO = 16;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } sb_t;

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         lat;
        int         wr;
    } vec_t;

    logic       clk = 1'b0, resetb = 1'b0;
    logic       i2c_req = 1'b0, i2c_we = 1'b0, i2c_lock = 1'b0;
    logic [7:0] i2c_addr = 8'h00, i2c_wdata = 8'h00;
    logic       uart_req = 1'b0, uart_we = 1'b0, uart_lock = 1'b0;
    logic [7:0] uart_addr = 8'h00, uart_wdata = 8'h00;
    logic       i2c_ack, uart_ack, rb_reg_en, rb_write_en, lock_err;
    logic [7:0] i2c_rdata, uart_rdata, rb_address, rb_data_write, rb_data_read;
    logic [1:0] grant_mon;

    int  checks = 0, failures = 0, cyc = 0;
    sb_t sb[$];

    rb_access_arbiter #(.RD_LATENCY(RD_LAT), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk(clk), .resetb(resetb),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_lock(i2c_lock), .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_lock(uart_lock), .uart_ack(uart_ack), .uart_rdata(uart_rdata),
        .rb_address(rb_address), .rb_data_write(rb_data_write), .rb_reg_en(rb_reg_en),
        .rb_write_en(rb_write_en), .rb_data_read(rb_data_read),
        .grant_mon(grant_mon), .lock_err(lock_err)
    );

    // Register-bank stand-in: read data is a fixed scramble of the presented address
    assign rb_data_read = rb_address ^ 8'h39;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input bit p, input bit we, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rdata);
        sb_t e;
        e = '{p, we, addr, wdata, rdata};
        sb.push_back(e);
    endtask

    function automatic logic [38:0] all_outs();
        return {i2c_ack, uart_ack, i2c_rdata, uart_rdata, rb_address, rb_data_write,
                rb_reg_en, rb_write_en, grant_mon, lock_err};
    endfunction

    // Bus monitor: invariants every cycle, access fields and ack/rdata against the scoreboard
    always @(negedge clk) begin
        sb_t e;
        chk("dual_ack", {63'd0, i2c_ack & uart_ack}, 64'd0);
        if (rb_write_en) chk("we_outside_access", {63'd0, rb_reg_en}, 64'd1);
        if (grant_mon == 2'b00)
            chk("idle_bus", {rb_reg_en, rb_write_en, rb_address, rb_data_write}, 64'd0);
        if (i2c_ack || uart_ack)
            chk("ack_bus", {rb_reg_en, rb_write_en, rb_address, rb_data_write}, 64'd0);
        if (rb_reg_en) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL access_unexpected: got access addr %0h expected none", rb_address);
            end else begin
                chk("access_fields",
                    {grant_mon, rb_write_en, rb_address, sb[0].we ? rb_data_write : 8'h00},
                    {sb[0].port ? 2'b10 : 2'b01, sb[0].we, sb[0].addr, sb[0].we ? sb[0].wdata : 8'h00});
            end
        end
        if (i2c_ack || uart_ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ack_unexpected: got acks %b%b expected none", uart_ack, i2c_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {uart_ack, i2c_ack}, e.port ? 2'b10 : 2'b01);
                if (!e.we) chk("read_data", e.port ? uart_rdata : i2c_rdata, e.rdata);
            end
        end
    end

    task automatic txn(input bit p, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       input bit lock, output int lat, output int wr);
        int c0 = cyc;
        bit done = 1'b0;
        wr  = 0;
        lat = -1;
        if (p) begin
            uart_we = we; uart_addr = addr; uart_wdata = wdata; uart_lock = lock; uart_req = 1'b1;
        end else begin
            i2c_we = we; i2c_addr = addr; i2c_wdata = wdata; i2c_lock = lock; i2c_req = 1'b1;
        end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rb_write_en && grant_mon == (p ? 2'b10 : 2'b01)) wr++;
            if (rb_reg_en && grant_mon == (p ? 2'b10 : 2'b01)) begin
                if (p) {uart_we, uart_addr, uart_wdata} = 17'($urandom);
                else   {i2c_we, i2c_addr, i2c_wdata} = 17'($urandom);
            end
            if (p ? uart_ack : i2c_ack) begin
                lat  = cyc - c0;
                done = 1'b1;
                if (p) uart_req = 1'b0;
                else   i2c_req = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: port %0d got no ack expected ack", p);
            if (p) uart_req = 1'b0;
            else   i2c_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        i2c_req = 1'b0; i2c_lock = 1'b0; uart_req = 1'b0; uart_lock = 1'b0;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    vec_t       vecs[7];
    int         l1, w1, l2, w2, n;
    bit         got;
    logic [7:0] last_i2c, last_uart;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'h12, 8'hA5, 8'h00, 2, 1};
        vecs[1] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h3C, 3, 0};
        vecs[2] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'hB9, 3, 0};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'h81, 8'h00, 2, 1};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h39, 3, 0};
        vecs[5] = '{1'b1, 1'b0, 8'hC6, 8'h00, 8'hFF, 3, 0};
        vecs[6] = '{1'b1, 1'b1, 8'h7E, 8'h5A, 8'h00, 2, 1};

        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);

        i2c_we = 1'b1; i2c_addr = 8'h44; i2c_wdata = 8'h55; i2c_req = 1'b1;
        expect_txn(1'b0, 1'b1, 8'h44, 8'h55, 8'h00);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        chk("no_grant_first_edge", {grant_mon, rb_reg_en}, 64'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (i2c_ack) begin
                got = 1'b1;
                i2c_req = 1'b0;
            end
        end
        chk("first_ack_seen", {63'd0, got}, 64'd1);

        last_i2c  = 8'h00;
        last_uart = 8'h00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            expect_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
            txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, l1, w1);
            chk("latency", l1, vecs[i].lat);
            chk("wr_pulses", w1, vecs[i].wr);
            if (!vecs[i].we) begin
                if (vecs[i].port) last_uart = vecs[i].rdata;
                else              last_i2c  = vecs[i].rdata;
            end
            chk("rdata_hold", {i2c_rdata, uart_rdata}, {last_i2c, last_uart});
        end

        do_reset();
        for (int k = 0; k < 4; k++) begin
            expect_txn(1'b0, 1'b1, 8'(8'h20 + k), 8'(8'hC0 + k), 8'h00);
            expect_txn(1'b1, 1'b0, 8'(8'h40 + k), 8'h00, 8'((8'h40 + k) ^ 8'h39));
        end
        fork
            begin
                for (int k = 0; k < 4; k++) txn(1'b0, 1'b1, 8'(8'h20 + k), 8'(8'hC0 + k), 1'b0, l1, w1);
            end
            begin
                for (int k = 0; k < 4; k++) txn(1'b1, 1'b0, 8'(8'h40 + k), 8'h00, 1'b0, l2, w2);
            end
        join

        do_reset();
        for (int k = 0; k < 3; k++) expect_txn(1'b0, 1'b1, 8'(8'h50 + k), 8'(8'hE0 + k), 8'h00);
        expect_txn(1'b1, 1'b1, 8'h99, 8'h66, 8'h00);
        fork
            begin
                for (int k = 0; k < 3; k++) txn(1'b0, 1'b1, 8'(8'h50 + k), 8'(8'hE0 + k), 1'b1, l1, w1);
                repeat (3) @(negedge clk);
                i2c_lock = 1'b0;
            end
            begin
                txn(1'b1, 1'b1, 8'h99, 8'h66, 1'b0, l2, w2);
            end
        join

        do_reset();
        expect_txn(1'b0, 1'b1, 8'h31, 8'h13, 8'h00);
        expect_txn(1'b1, 1'b1, 8'h32, 8'h23, 8'h00);
        fork
            begin
                txn(1'b0, 1'b1, 8'h31, 8'h13, 1'b1, l1, w1);
                n   = 0;
                got = 1'b0;
                for (int i = 0; i < 40 && !got; i++) begin
                    @(negedge clk);
                    if (lock_err) got = 1'b1;
                    else if (grant_mon == 2'b01 && !rb_reg_en) n++;
                end
                chk("lock_err_seen", {63'd0, got}, 64'd1);
                chk("locked_cycles", n, LOCK_TO);
                @(negedge clk);
                chk("lock_err_pulse", {63'd0, lock_err}, 64'd0);
                i2c_lock = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                txn(1'b1, 1'b1, 8'h32, 8'h23, 1'b0, l2, w2);
            end
        join

        do_reset();
        expect_txn(1'b1, 1'b0, 8'h05, 8'h00, 8'h3C);
        txn(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, l2, w2);
        chk("rdata_before_reset", uart_rdata, 8'h3C);
        @(negedge clk);
        expect_txn(1'b1, 1'b0, 8'h0A, 8'h00, 8'h33);
        uart_we = 1'b0; uart_addr = 8'h0A; uart_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rb_reg_en) got = 1'b1;
        end
        chk("abort_access_seen", {63'd0, got}, 64'd1);
        @(posedge clk);
        #2 resetb = 1'b0;
        uart_req = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_ack", sb.size(), 1);
        sb.delete();
        resetb = 1'b1;
        repeat (3) @(negedge clk);
        expect_txn(1'b0, 1'b1, 8'h6B, 8'h77, 8'h00);
        txn(1'b0, 1'b1, 8'h6B, 8'h77, 1'b0, l1, w1);
        chk("post_reset_latency", l1, 2);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rb_access_arbiter.md
RB_ACCESS_ARBITER -- requirements
Module: rb_access_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1, range 1..7: cycles between read address presentation and rb_data_read sampling.
REQ-002 Parameter LOCK_TIMEOUT, default 1024, range 2..65535: max cycles a port may hold LOCKED.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 resetb  in  1  asynchronous, active-low reset.
REQ-005 i2c_req / uart_req  in  1  access request; held high until the matching ack.
REQ-006 i2c_we / uart_we  in  1  1 = write, 0 = read.
REQ-007 i2c_addr / uart_addr  in  8  register address.
REQ-008 i2c_wdata / uart_wdata  in  8  write data.
REQ-009 i2c_lock / uart_lock  in  1  keep grant after ack for a multi-byte stream.
REQ-010 i2c_ack / uart_ack  out  1  one-cycle completion pulse.
REQ-011 i2c_rdata / uart_rdata  out  8  read data; valid with ack; held until that port's next read ack.
REQ-012 rb_address  out  8; rb_data_write  out  8; rb_reg_en  out  1; rb_write_en  out  1  register-bank access port.
REQ-013 rb_data_read  in  8  register-bank read data.
REQ-014 grant_mon  out  2  00 none, 01 I2C, 10 UART; lock_err  out  1  one-cycle pulse on lock timeout.

Function
REQ-015 The block SHALL implement states IDLE, ACCESS, WAIT_RD, ACK, LOCKED.
REQ-016 IDLE: only one req high -> grant it; both high -> grant the port not in last_served; the block latches we/addr/wdata and owner, then enters ACCESS.
REQ-017 ACCESS lasts exactly one cycle: rb_reg_en=1, rb_write_en=latched we, rb_address/rb_data_write = latched values; write -> ACK, read -> WAIT_RD.
REQ-018 WAIT_RD lasts RD_LATENCY cycles with rb_address held, rb_reg_en=0, rb_write_en=0; rb_data_read sampled on the final edge into the owner's rdata register.
REQ-019 Latency: req sampled in IDLE at edge N -> write ack during cycle N+2; read ack during cycle N+2+RD_LATENCY.
REQ-020 ACK lasts one cycle, asserting owner's ack only; requests are not sampled in ACK.
REQ-021 Leaving ACK: owner's lock high -> LOCKED with lock counter cleared; else IDLE with last_served = owner.
REQ-022 LOCKED: owner req high -> ACCESS (same latch rules); other port's req ignored; owner lock low with no owner req -> IDLE, last_served = owner.
REQ-023 The lock counter SHALL increment each LOCKED cycle; on reaching LOCK_TIMEOUT -> IDLE, lock_err pulse, last_served = owner, so a pending other port wins next.
REQ-024 Owner req and lock both high in LOCKED at timeout: timeout wins; owner re-arbitrates from IDLE.
REQ-025 rb_reg_en and rb_write_en SHALL never be high outside ACCESS; rb_address/rb_data_write SHALL be 0 in IDLE, LOCKED and ACK.
REQ-026 Requester field changes after grant SHALL not affect the in-flight access.
REQ-027 grant_mon SHALL show the owner in ACCESS, WAIT_RD, ACK, LOCKED, and 00 in IDLE.

Reset
REQ-028 Asserting resetb low SHALL immediately force IDLE and clear all outputs, rdata registers, lock counter and owner; last_served resets to UART (I2C wins first tie).
REQ-029 Reset during ACCESS/WAIT_RD SHALL abort the access with no ack issued and rb_write_en low without waiting for clk.
REQ-030 Reset release SHALL be synchronised so first arbitration occurs no earlier than the second rising edge after release.

Verification
REQ-031 I2C write addr 0x12 data 0xA5, UART idle -> rb_write_en one cycle with 0x12/0xA5, i2c_ack at cycle N+2, uart_ack never.
REQ-032 UART read 0x05, RD_LATENCY=1, bank returns 0x3C -> uart_ack at N+3 with uart_rdata=0x3C, rb_write_en never high.
REQ-033 Both req in same cycle, 4 back-to-back each -> grants alternate I2C, UART, I2C, UART..., no ack on both ports in one cycle.
REQ-034 I2C lock high with 3 writes while UART req high -> 3 I2C acks before any UART access; UART granted after lock drops.
REQ-035 LOCK_TIMEOUT=16, I2C holds lock idle -> lock_err pulse after 16 LOCKED cycles, UART then granted.
REQ-036 resetb low in WAIT_RD cycle -> no ack, all outputs 0 asynchronously, next request served normally after release.
